time_set_ctrl: RTL

TIME_SET_CTRL -- requirements
Module: time_set_ctrl

---
 rtl/time_set_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/time_set_ctrl.sv
// MM:SS time-setting controller: switch sync/debounce, press detection, SET FSM with BCD edit.
// Optional hold-to-repeat on INC/DEC is enabled by defining TIME_SET_AUTOREPEAT_EN.
module time_set_ctrl #(
    parameter int DB_CYCLES  = 500000,
    parameter int RPT_DELAY  = 25000000,
    parameter int RPT_PERIOD = 5000000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] SW,
    input  logic [7:0] CUR_MIN,
    input  logic [7:0] CUR_SEC,
    output logic       SETTING,
    output logic       FIELD,
    output logic [7:0] SET_MIN,
    output logic [7:0] SET_SEC,
    output logic       LOAD
);

    localparam int DBW = $clog2(DB_CYCLES + 1);
    localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

    localparam logic [1:0] ST_RUN = 2'd0;
    localparam logic [1:0] ST_SEC = 2'd1;
    localparam logic [1:0] ST_MIN = 2'd2;

    logic [3:0]     sync1, sync2, db, db_prev, press;
    logic [DBW-1:0] db_cnt [4];
    logic [1:0]     state;
    logic           inc_ev, dec_ev;

    function automatic logic [7:0] bcd_clean(input logic [7:0] v);
        if (v[7:4] > 4'd5 || v[3:0] > 4'd9) return 8'h00;
        return v;
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        if (v >= 8'h59) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v);
        if (v == 8'h00) return 8'h59;
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    // Debounced level flips only after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            sync1   <= '0;
            sync2   <= '0;
            db      <= '0;
            db_prev <= '0;
            press   <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            sync1   <= SW;
            sync2   <= sync1;
            db_prev <= db;
            press   <= db & ~db_prev;
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == db[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    db[i]     <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

`ifdef TIME_SET_AUTOREPEAT_EN
    localparam int RW = $clog2(RPT_DELAY + RPT_PERIOD + 1);

    logic [RW-1:0] rpt_cnt [2];
    logic [1:0]    rpt_first, rpt_hit;

    // rpt_cnt counts cycles since the press pulse (or last repeat); 0 means idle.
    always_comb begin
        rpt_hit = '0;
        for (int j = 0; j < 2; j++)
            rpt_hit[j] = db[j+2] && !press[j+2] &&
                         (rpt_cnt[j] == (rpt_first[j] ? RW'(RPT_DELAY) : RW'(RPT_PERIOD)));
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rpt_first <= '0;
            for (int j = 0; j < 2; j++) rpt_cnt[j] <= '0;
        end else begin
            for (int j = 0; j < 2; j++) begin
                if (press[j+2]) begin
                    rpt_cnt[j]   <= RW'(1);
                    rpt_first[j] <= 1'b1;
                end else if (!db[j+2]) begin
                    rpt_cnt[j]   <= '0;
                end else if (rpt_hit[j]) begin
                    rpt_cnt[j]   <= RW'(1);
                    rpt_first[j] <= 1'b0;
                end else if (rpt_cnt[j] != '0) begin
                    rpt_cnt[j]   <= rpt_cnt[j] + 1'b1;
                end
            end
        end
    end

    assign inc_ev = press[2] | rpt_hit[0];
    assign dec_ev = press[3] | rpt_hit[1];
`else
    assign inc_ev = press[2];
    assign dec_ev = press[3];
`endif

    // Priority: MODE > SEL > INC/DEC; INC and DEC together cancel.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state   <= ST_RUN;
            SET_MIN <= 8'h00;
            SET_SEC <= 8'h00;
            LOAD    <= 1'b0;
        end else begin
            LOAD <= 1'b0;
            if (state == ST_RUN) begin
                if (press[0]) begin
                    state   <= ST_SEC;
                    SET_MIN <= bcd_clean(CUR_MIN);
                    SET_SEC <= bcd_clean(CUR_SEC);
                end
            end else if (press[0]) begin
                state <= ST_RUN;
                LOAD  <= 1'b1;
            end else if (press[1]) begin
                state <= (state == ST_MIN) ? ST_SEC : ST_MIN;
            end else if (inc_ev ^ dec_ev) begin
                if (state == ST_MIN)
                    SET_MIN <= inc_ev ? bcd_inc(SET_MIN) : bcd_dec(SET_MIN);
                else
                    SET_SEC <= inc_ev ? bcd_inc(SET_SEC) : bcd_dec(SET_SEC);
            end
        end
    end

    assign SETTING = (state != ST_RUN);
    assign FIELD   = (state == ST_MIN);

endmodule
